ddrx_mode_reg_ctrl: RTL and testbench

Parametrised mode-register configuration block for the DDRx controller, replacing the fixed four-register, 19-bit config interface. Holds NUM_MR shadow/active mode-register pairs plus the tMRD/tMOD timing fields, all writable over a simple register port. On a software commit it issues one MRS request per modified register to the command scheduler, spaced by tMRD, using tMOD after the last request. Active values drive the rest of the controller directly.

---
 rtl/ddrx_mode_reg_ctrl_if.sv | 30 +++
 rtl/ddrx_mode_reg_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ddrx_mode_reg_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ddrx_mode_reg_ctrl_if.sv
// Register-port and MRS-request bundle for the DDRx mode-register block.
// The master side is software/scheduler and the slave side is the block.
interface ddrx_mode_reg_ctrl_if #(
    parameter int NUM_MR = 4,
    parameter int MR_W   = 19
);
    localparam int ADDR_W = $clog2(NUM_MR + 2);
    localparam int IDX_W  = (NUM_MR > 1) ? $clog2(NUM_MR) : 1;

    logic              cfg_wr_en;
    logic              cfg_rd_en;
    logic [ADDR_W-1:0] cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic              cfg_rvalid;
    logic              mrs_valid;
    logic              mrs_ready;
    logic [IDX_W-1:0]  mrs_idx;
    logic [MR_W-1:0]   mrs_data;

    modport master (
        output cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata, mrs_ready,
        input  cfg_rdata, cfg_rvalid, mrs_valid, mrs_idx, mrs_data
    );

    modport slave (
        input  cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata, mrs_ready,
        output cfg_rdata, cfg_rvalid, mrs_valid, mrs_idx, mrs_data
    );
endinterface

// File: rtl/ddrx_mode_reg_ctrl.sv
// Shadow/active mode registers with a commit sequencer that issues one
// MRS per dirty register, spaced by tMRD and closed out by tMOD.
module ddrx_mode_reg_ctrl #(
    parameter int NUM_MR   = 4,
    parameter int MR_W     = 19,
    parameter int TIMER_W  = 8,
    parameter int TMRD_RST = 4,
    parameter int TMOD_RST = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ddrx_mode_reg_ctrl_if.slave    bus,
    output logic [NUM_MR*MR_W-1:0] msr_active,
    output logic [TIMER_W-1:0]     tmrd,
    output logic [TIMER_W-1:0]     tmod,
    output logic                   busy
);
    localparam int ADDR_W = $clog2(NUM_MR + 2);
    localparam int IDX_W  = (NUM_MR > 1) ? $clog2(NUM_MR) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state;
    logic [MR_W-1:0]    shadow [NUM_MR];
    logic [MR_W-1:0]    active [NUM_MR];
    logic [NUM_MR-1:0]  dirty;
    logic [TIMER_W-1:0] tmrd_q;
    logic [TIMER_W-1:0] tmod_q;
    logic [TIMER_W-1:0] cnt;
    logic               err;
    logic [31:0]        rdata_q;
    logic               rvalid_q;

    logic [IDX_W-1:0]   aidx;
    logic [IDX_W-1:0]   sel;
    logic [NUM_MR-1:0]  sel_oh;
    logic [NUM_MR-1:0]  rest;
    logic               is_mr;
    logic               is_tim;
    logic               is_ctrl;
    logic               wr_mr;
    logic               wr_tim;
    logic               wr_ctrl;
    logic               wr_drop;
    logic               commit;
    logic               fire;
    logic [TIMER_W-1:0] load_raw;
    logic [TIMER_W-1:0] load_val;
    logic [31:0]        rd_mux;
    logic [7:0]         dirty8;

    assign aidx    = bus.cfg_addr[IDX_W-1:0];
    assign is_mr   = bus.cfg_addr < ADDR_W'(NUM_MR);
    assign is_tim  = bus.cfg_addr == ADDR_W'(NUM_MR);
    assign is_ctrl = bus.cfg_addr == ADDR_W'(NUM_MR + 1);

    assign busy    = state != S_IDLE;
    assign wr_mr   = bus.cfg_wr_en && is_mr && !busy;
    assign wr_tim  = bus.cfg_wr_en && is_tim && !busy;
    assign wr_ctrl = bus.cfg_wr_en && is_ctrl;
    assign wr_drop = bus.cfg_wr_en && (is_mr || is_tim) && busy;
    assign commit  = wr_ctrl && bus.cfg_wdata[0] && (dirty != '0);

    // Lowest dirty register goes first.
    always_comb begin
        sel = '0;
        for (int i = NUM_MR - 1; i >= 0; i--) begin
            if (dirty[i]) sel = IDX_W'(i);
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_MR; i++) begin
            sel_oh[i] = sel == IDX_W'(i);
        end
    end

    assign rest     = dirty & ~sel_oh;
    assign fire     = bus.mrs_valid && bus.mrs_ready;
    assign load_raw = (rest != '0) ? tmrd_q : tmod_q;
    assign load_val = (load_raw == '0) ? TIMER_W'(1) : load_raw;

    assign bus.mrs_valid  = state == S_ISSUE;
    assign bus.mrs_idx    = sel;
    assign bus.mrs_data   = shadow[sel];
    assign bus.cfg_rdata  = rdata_q;
    assign bus.cfg_rvalid = rvalid_q;
    assign tmrd           = tmrd_q;
    assign tmod           = tmod_q;

    for (genvar g = 0; g < NUM_MR; g++) begin : g_act
        assign msr_active[g*MR_W +: MR_W] = active[g];
    end

    always_comb begin
        rd_mux = '0;
        dirty8 = 8'(dirty);
        unique case (1'b1)
            is_mr:   rd_mux = 32'(shadow[aidx]);
            is_tim: begin
                rd_mux[TIMER_W-1:0]   = tmrd_q;
                rd_mux[16 +: TIMER_W] = tmod_q;
            end
            is_ctrl: rd_mux = {16'd0, dirty8, 6'd0, err, busy};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dirty    <= '0;
            tmrd_q   <= TIMER_W'(TMRD_RST);
            tmod_q   <= TIMER_W'(TMOD_RST);
            cnt      <= '0;
            err      <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            for (int i = 0; i < NUM_MR; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            rvalid_q <= bus.cfg_rd_en;
            if (bus.cfg_rd_en) rdata_q <= rd_mux;
            if (wr_mr) begin
                shadow[aidx] <= bus.cfg_wdata[MR_W-1:0];
                dirty[aidx]  <= 1'b1;
            end
            if (wr_tim) begin
                tmrd_q <= bus.cfg_wdata[TIMER_W-1:0];
                tmod_q <= bus.cfg_wdata[16 +: TIMER_W];
            end
            if (wr_drop) err <= 1'b1;
            else if (wr_ctrl && bus.cfg_wdata[1]) err <= 1'b0;
            unique case (state)
                S_IDLE: if (commit) state <= S_ISSUE;
                S_ISSUE: begin
                    if (fire) begin
                        for (int i = 0; i < NUM_MR; i++) begin
                            if (sel_oh[i]) begin
                                active[i] <= shadow[i];
                                dirty[i]  <= 1'b0;
                            end
                        end
                        cnt   <= load_val;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - TIMER_W'(1);
                    if (cnt <= TIMER_W'(1)) begin
                        state <= (dirty != '0) ? S_ISSUE : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddrx_mode_reg_ctrl.sv
// Directed bench for ddrx_mode_reg_ctrl: register map, MRS sequencing,
// handshake stalls, busy-write errors, zero timings and async reset.
module tb_ddrx_mode_reg_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [75:0] msr_active;
    logic [7:0]  tmrd;
    logic [7:0]  tmod;
    logic        busy;
    int          tests = 0;
    int          failed = 0;
    int          n;

    ddrx_mode_reg_ctrl_if #(.NUM_MR(4), .MR_W(19)) bus ();

    ddrx_mode_reg_ctrl #(
        .NUM_MR(4), .MR_W(19), .TIMER_W(8), .TMRD_RST(4), .TMOD_RST(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .msr_active(msr_active),
        .tmrd(tmrd),
        .tmod(tmod),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.cfg_wr_en = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        step();
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                      input string tag);
        bus.cfg_rd_en = 1'b1;
        bus.cfg_addr  = a;
        step();
        bus.cfg_rd_en = 1'b0;
        chk({tag, "_rvalid"}, 128'(bus.cfg_rvalid), 128'(1));
        chk(tag, 128'(bus.cfg_rdata), 128'(exp));
    endtask

    task automatic count_low(output int c);
        c = 0;
        while (!bus.mrs_valid && c < 64) begin
            c++;
            step();
        end
    endtask

    task automatic count_busy(output int c);
        c = 0;
        while (busy && c < 64) begin
            c++;
            step();
        end
    endtask

    initial begin
        bus.cfg_wr_en = 1'b0;
        bus.cfg_rd_en = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.mrs_ready = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_active", 128'(msr_active), 128'(0));
        chk("rst_tmrd", 128'(tmrd), 128'(4));
        chk("rst_tmod", 128'(tmod), 128'(12));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(bus.mrs_valid), 128'(0));
        chk("rst_rvalid", 128'(bus.cfg_rvalid), 128'(0));
        #11 rst_n = 1'b1;
        step();

        // 1: timing register read and read-strobe shape
        rd(3'd4, 32'h000C_0004, "rd_timing");
        step();
        chk("rvalid_drop", 128'(bus.cfg_rvalid), 128'(0));
        rd(3'd7, 32'h0, "rd_oor");

        // 2: two-register commit
        bus.mrs_ready = 1'b1;
        wr(3'd1, 32'hFFF0_1234);
        wr(3'd3, 32'h0007_FFFF);
        rd(3'd1, 32'h0000_1234, "rd_mr1");
        rd(3'd5, 32'h0000_0A00, "rd_ctrl_dirty");
        wr(3'd5, 32'h1);
        chk("t2_busy", 128'(busy), 128'(1));
        chk("t2_valid", 128'(bus.mrs_valid), 128'(1));
        chk("t2_idx1", 128'(bus.mrs_idx), 128'(1));
        chk("t2_data1", 128'(bus.mrs_data), 128'(19'h01234));
        step();
        chk("t2_act1", 128'(msr_active[19 +: 19]), 128'(19'h01234));
        count_low(n);
        chk("t2_gap_tmrd", 128'(n), 128'(4));
        chk("t2_idx3", 128'(bus.mrs_idx), 128'(3));
        chk("t2_data3", 128'(bus.mrs_data), 128'(19'h7FFFF));
        step();
        count_busy(n);
        chk("t2_tail_tmod", 128'(n), 128'(12));
        chk("t2_act3", 128'(msr_active[57 +: 19]), 128'(19'h7FFFF));
        rd(3'd5, 32'h0, "rd_ctrl_clean");

        // 3: stalled handshake
        bus.mrs_ready = 1'b0;
        wr(3'd2, 32'h0000_0ABC);
        wr(3'd5, 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", 128'(bus.mrs_valid), 128'(1));
            chk("t3_idx", 128'(bus.mrs_idx), 128'(2));
            chk("t3_data", 128'(bus.mrs_data), 128'(19'h00ABC));
            chk("t3_act_hold", 128'(msr_active[38 +: 19]), 128'(0));
            step();
        end
        bus.mrs_ready = 1'b1;
        step();
        chk("t3_act2", 128'(msr_active[38 +: 19]), 128'(19'h00ABC));
        chk("t3_valid_low", 128'(bus.mrs_valid), 128'(0));
        count_busy(n);
        chk("t3_tail", 128'(n), 128'(12));

        // 4: writes while busy
        bus.mrs_ready = 1'b0;
        wr(3'd0, 32'h111);
        wr(3'd5, 32'h1);
        wr(3'd0, 32'h222);
        rd(3'd0, 32'h111, "t4_shadow_kept");
        rd(3'd5, 32'h0103, "t4_err_set");
        wr(3'd5, 32'h2);
        rd(3'd5, 32'h0101, "t4_err_clr");
        bus.mrs_ready = 1'b1;
        step();
        chk("t4_act0", 128'(msr_active[0 +: 19]), 128'(19'h111));
        count_busy(n);
        chk("t4_tail", 128'(n), 128'(12));

        // 5: zero timings, simultaneous write+read, empty commit
        wr(3'd4, 32'h0);
        rd(3'd4, 32'h0, "t5_timing0");
        bus.cfg_wr_en = 1'b1;
        bus.cfg_rd_en = 1'b1;
        bus.cfg_addr  = 3'd0;
        bus.cfg_wdata = 32'h5;
        step();
        bus.cfg_wr_en = 1'b0;
        bus.cfg_rd_en = 1'b0;
        chk("t5_rw_old", 128'(bus.cfg_rdata), 128'(32'h111));
        wr(3'd2, 32'h6);
        wr(3'd5, 32'h1);
        chk("t5_idx0", 128'(bus.mrs_idx), 128'(0));
        step();
        count_low(n);
        chk("t5_gap1", 128'(n), 128'(1));
        chk("t5_idx2", 128'(bus.mrs_idx), 128'(2));
        step();
        count_busy(n);
        chk("t5_tail1", 128'(n), 128'(1));
        chk("t5_act2", 128'(msr_active[38 +: 19]), 128'(19'h6));
        wr(3'd5, 32'h1);
        chk("t5_nop_busy", 128'(busy), 128'(0));
        step();
        chk("t5_nop_busy2", 128'(busy), 128'(0));

        // 6: reset in the middle of a sequence
        wr(3'd4, 32'h000C_0004);
        wr(3'd0, 32'h10);
        wr(3'd1, 32'h20);
        wr(3'd2, 32'h30);
        wr(3'd5, 32'h1);
        step();
        chk("t6_act0", 128'(msr_active[0 +: 19]), 128'(19'h10));
        chk("t6_in_wait", 128'(bus.mrs_valid), 128'(0));
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_valid", 128'(bus.mrs_valid), 128'(0));
        chk("t6_active", 128'(msr_active), 128'(0));
        chk("t6_tmrd", 128'(tmrd), 128'(4));
        chk("t6_tmod", 128'(tmod), 128'(12));
        #12 rst_n = 1'b1;
        step();
        rd(3'd5, 32'h0, "t6_dirty0");
        chk("t6_active_post", 128'(msr_active), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
